// File: rtl/matrix_mac_sequencer.sv
// matrix_mac_sequencer: steps one MAC unit through C = A x B, issuing operand reads and
// handing each finished dot product to a result sink over valid/ready.
module matrix_mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM_WIDTH  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DIM_WIDTH-1:0]  dim_m_i,
    input  logic [DIM_WIDTH-1:0]  dim_n_i,
    input  logic [DIM_WIDTH-1:0]  dim_k_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] a_addr_o,
    output logic [ADDR_WIDTH-1:0] b_addr_o,
    output logic                  mac_clear_o,
    output logic                  mac_enable_o,
    input  logic [ACC_WIDTH-1:0]  mac_result_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [ADDR_WIDTH-1:0] res_addr_o,
    output logic [ACC_WIDTH-1:0]  res_data_o
);

    if (ADDR_WIDTH < 2*DIM_WIDTH || ACC_WIDTH < 2*DATA_WIDTH+DIM_WIDTH) begin : g_bad_params
        $error("matrix_mac_sequencer: address or accumulator width too small");
    end

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, WRITE, FINISH} state_e;

    localparam logic [DIM_WIDTH-1:0] ONE = 1;

    state_e                state_q, state_d;
    logic [DIM_WIDTH-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
    logic [DIM_WIDTH-1:0]  i_q, i_d, j_q, j_d, kc_q, kc_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d, a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
    logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
    logic                  res_valid_q, res_valid_d, mac_en_q, mac_en_d;
    logic                  drain_q, drain_d, zero_q, zero_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            m_q         <= '0;
            n_q         <= '0;
            k_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            kc_q        <= '0;
            row_q       <= '0;
            a_addr_q    <= '0;
            b_addr_q    <= '0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            mac_en_q    <= 1'b0;
            drain_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            n_q         <= n_d;
            k_q         <= k_d;
            i_q         <= i_d;
            j_q         <= j_d;
            kc_q        <= kc_d;
            row_q       <= row_d;
            a_addr_q    <= a_addr_d;
            b_addr_q    <= b_addr_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            mac_en_q    <= mac_en_d;
            drain_q     <= drain_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        n_d         = n_q;
        k_d         = k_q;
        i_d         = i_q;
        j_d         = j_q;
        kc_d        = kc_q;
        row_d       = row_q;
        a_addr_d    = a_addr_q;
        b_addr_d    = b_addr_q;
        res_addr_d  = res_addr_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        mac_en_d    = (state_q == FEED);
        drain_d     = drain_q;
        zero_d      = zero_q;
        case (state_q)
            IDLE: if (start_i) begin
                m_d = dim_m_i;
                n_d = dim_n_i;
                k_d = dim_k_i;
                if (dim_m_i == '0 || dim_n_i == '0 || dim_k_i == '0) begin
                    zero_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    i_d        = '0;
                    j_d        = '0;
                    row_d      = '0;
                    res_addr_d = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                a_addr_d = row_q;
                b_addr_d = ADDR_WIDTH'(j_q);
                kc_d     = '0;
                state_d  = FEED;
            end
            // Addresses stop on the final read so they show the last operand fetched.
            FEED: if (kc_q == k_q - ONE) begin
                drain_d = 1'b0;
                state_d = DRAIN;
            end else begin
                kc_d     = kc_q + ONE;
                a_addr_d = a_addr_q + 1'b1;
                b_addr_d = b_addr_q + ADDR_WIDTH'(n_q);
            end
            DRAIN: if (drain_q) begin
                res_valid_d = 1'b1;
                res_data_d  = mac_result_i;
                drain_d     = 1'b0;
                state_d     = WRITE;
            end else begin
                drain_d = 1'b1;
            end
            WRITE: if (res_ready_i) begin
                res_valid_d = 1'b0;
                res_addr_d  = res_addr_q + 1'b1;
                j_d         = (j_q == n_q - ONE) ? '0 : j_q + ONE;
                i_d         = (j_q == n_q - ONE) ? i_q + ONE : i_q;
                row_d       = (j_q == n_q - ONE) ? row_q + ADDR_WIDTH'(k_q) : row_q;
                state_d     = (i_q == m_q - ONE && j_q == n_q - ONE) ? FINISH : CLEAR;
            end
            // An empty product spends one extra cycle here so done lands two cycles after start.
            FINISH: begin
                zero_d  = 1'b0;
                state_d = zero_q ? FINISH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o       = (state_q != IDLE) && (state_q != FINISH);
    assign done_o       = (state_q == FINISH) && !zero_q;
    assign rd_en_o      = (state_q == FEED);
    assign mac_clear_o  = (state_q == CLEAR);
    assign mac_enable_o = mac_en_q;
    assign a_addr_o     = a_addr_q;
    assign b_addr_o     = b_addr_q;
    assign res_valid_o  = res_valid_q;
    assign res_addr_o   = res_addr_q;
    assign res_data_o   = res_data_q;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// tb_matrix_mac_sequencer: directed products against operand RAM and MAC models, with a
// scoreboard queue checked by an independent result monitor.
module tb_matrix_mac_sequencer;
    localparam int DW = 8, MW = 4, AW = 8, CW = 20;

    logic          clk = 0, rst_n = 0, start = 0, res_ready = 1;
    logic [MW-1:0] dm = 0, dn = 0, dk = 0;
    logic          busy, done, rd_en, mac_clear, mac_enable, res_valid;
    logic [AW-1:0] a_addr, b_addr, res_addr;
    logic [CW-1:0] mac_result, res_data;

    always #5 clk = ~clk;

    matrix_mac_sequencer #(.DATA_WIDTH(DW), .DIM_WIDTH(MW), .ADDR_WIDTH(AW), .ACC_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .dim_m_i(dm), .dim_n_i(dn), .dim_k_i(dk),
        .busy_o(busy), .done_o(done), .rd_en_o(rd_en),
        .a_addr_o(a_addr), .b_addr_o(b_addr),
        .mac_clear_o(mac_clear), .mac_enable_o(mac_enable), .mac_result_i(mac_result),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_addr_o(res_addr), .res_data_o(res_data)
    );

    // Synchronous operand RAMs (1-cycle latency) feeding a MAC accumulator.
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic [DW-1:0] a_q = 0, b_q = 0;
    logic [CW-1:0] acc = 0;
    always @(posedge clk) begin
        if (rd_en) begin
            a_q <= mem_a[a_addr];
            b_q <= mem_b[b_addr];
        end
        if (mac_clear) acc <= '0;
        else if (mac_enable) acc <= acc + CW'(a_q) * CW'(b_q);
    end
    assign mac_result = acc;

    typedef struct {int a; int d;} exp_t;
    exp_t exp_q[$];
    int vectors = 0, errors = 0;

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int a, input int d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) if (rst_n) begin
        if (mac_clear && mac_enable) begin
            errors++;
            $display("FAIL clear_enable_overlap: got both high, expected exclusive");
        end
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d, expected none", res_addr, res_data);
            end else begin
                check("res_addr", res_addr, exp_q[0].a);
                check("res_data", res_data, exp_q[0].d);
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Optional backpressure: hold res_ready low for the first 5 cycles of each offered element.
    bit stall_en = 0;
    int stall_cnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_en && res_valid && stall_cnt < 5) begin
            res_ready = 0;
            stall_cnt++;
        end else begin
            res_ready = 1;
            if (!res_valid) stall_cnt = 0;
        end
    end

    int el;
    int rd_cnt [256];
    int me_cnt [256];
    int aseq[$], bseq[$];

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_a_addr"}, a_addr, 0);
        check({tag, "_b_addr"}, b_addr, 0);
        check({tag, "_mac_clear"}, mac_clear, 0);
        check({tag, "_mac_enable"}, mac_enable, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_addr"}, res_addr, 0);
        check({tag, "_res_data"}, res_data, 0);
    endtask

    task automatic begin_start(input int m, input int n, input int k);
        @(posedge clk);
        #1;
        start = 1;
        dm = MW'(m);
        dn = MW'(n);
        dk = MW'(k);
        el = -1;
        foreach (rd_cnt[x]) begin
            rd_cnt[x] = 0;
            me_cnt[x] = 0;
        end
        aseq.delete();
        bseq.delete();
    endtask

    task automatic run(input int m, input int n, input int k, input int exp_lat, input bit poke);
        int c = 0;
        begin_start(m, n, k);
        do begin
            @(posedge clk);
            #1;
            c++;
            start = poke && c == 4;
            if (poke && c == 4) begin
                dm = 1;
                dn = 1;
                dk = 1;
            end
            if (mac_clear) el++;
            if (rd_en) begin
                aseq.push_back(a_addr);
                bseq.push_back(b_addr);
                if (el >= 0 && el < 256) rd_cnt[el]++;
            end
            if (mac_enable && el >= 0 && el < 256) me_cnt[el]++;
            if (c == 1) check("busy_after_start", busy, (m != 0 && n != 0 && k != 0));
        end while (!done && c < 6000);
        check("done_latency", c, exp_lat);
        check("busy_at_done", busy, 0);
        @(posedge clk);
        #1;
        check("done_single_cycle", done, 0);
        check("all_results_written", exp_q.size(), 0);
    endtask

    task automatic load_basic();
        foreach (mem_a[x]) begin
            mem_a[x] = 0;
            mem_b[x] = 0;
        end
        mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
        mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
    endtask

    task automatic push_basic();
        push_exp(0, 19);
        push_exp(1, 22);
        push_exp(2, 43);
        push_exp(3, 50);
    endtask

    task automatic hold_reset(input string tag);
        rst_n = 0;
        #1;
        check_zero(tag);
        exp_q.delete();
        for (int x = 0; x < 4; x++) begin
            @(posedge clk);
            #1;
            check({tag, "_no_done"}, done, 0);
        end
        rst_n = 1;
        @(posedge clk);
        #1;
        check({tag, "_idle_after"}, busy, 0);
    endtask

    initial begin
        load_basic();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1;

        push_basic();
        run(2, 2, 2, 25, 0);

        stall_en = 1;
        push_basic();
        run(2, 2, 2, 45, 0);
        stall_en = 0;

        foreach (mem_a[x]) begin
            mem_a[x] = (x < 4) ? 1 : 0;
            mem_b[x] = (x < 12) ? 2 : 0;
        end
        for (int j = 0; j < 3; j++) push_exp(j, 8);
        run(1, 3, 4, 25, 0);
        check("nsq_elements", el, 2);
        check("nsq_reads", bseq.size(), 12);
        for (int j = 0; j < 3; j++) begin
            check("nsq_rd_en_cycles", rd_cnt[j], 4);
            check("nsq_mac_enable_cycles", me_cnt[j], 4);
            for (int k = 0; k < 4; k++) if (bseq.size() == 12) begin
                check("nsq_b_addr", bseq[j*4+k], j + 3*k);
                check("nsq_a_addr", aseq[j*4+k], k);
            end
        end

        foreach (mem_a[x]) begin
            mem_a[x] = 255;
            mem_b[x] = 255;
        end
        for (int x = 0; x < 225; x++) push_exp(x, 975375);
        run(15, 15, 15, 4276, 0);
        check("max_last_a_addr", aseq.size() ? aseq[$] : -1, 224);
        check("max_last_b_addr", bseq.size() ? bseq[$] : -1, 224);
        check("max_read_count", aseq.size(), 225*15);

        run(2, 2, 0, 2, 0);
        check("zero_k_reads", aseq.size(), 0);

        load_basic();
        push_basic();
        begin_start(2, 2, 2);
        repeat (3) @(posedge clk);
        #1;
        start = 0;
        check("mid_feed_rd_en", rd_en, 1);
        hold_reset("rst_feed");

        stall_en = 1;
        push_basic();
        begin_start(2, 2, 2);
        @(posedge clk);
        #1;
        start = 0;
        for (int x = 0; x < 20 && !res_valid; x++) begin
            @(posedge clk);
            #1;
        end
        check("mid_write_valid", res_valid, 1);
        hold_reset("rst_write");
        stall_en = 0;

        push_basic();
        run(2, 2, 2, 25, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/matrix_mac_sequencer.md
Name: matrix_mac_sequencer

Overview:
Control block that drives one matrix MAC unit through a full C = A x B matrix product.
- A is M x K and B is K x N, both stored row-major in external synchronous operand RAMs.
- It issues operand read addresses, produces the per-element clear/enable pulses for the MAC, and collects each finished dot product.
- Each result goes to a result buffer over a valid/ready handshake, one element at a time.

Parameters:
DATA_WIDTH, 8, operand element width (matches MAC unit)
DIM_WIDTH, 4, width of each matrix dimension field (dims 1..2^DIM_WIDTH-1)
ADDR_WIDTH, 8, operand/result address width; must be >= 2*DIM_WIDTH
ACC_WIDTH, 20, MAC accumulator/result width; must be >= 2*DATA_WIDTH+DIM_WIDTH

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin a product; sampled only in IDLE
dim_m  input  DIM_WIDTH  rows of A; sampled with start
dim_n  input  DIM_WIDTH  columns of B; sampled with start
dim_k  input  DIM_WIDTH  inner dimension; sampled with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the product completes
rd_en  output  1  operand RAM read strobe
a_addr  output  ADDR_WIDTH  A RAM address (i*K + k)
b_addr  output  ADDR_WIDTH  B RAM address (k*N + j)
mac_clear  output  1  clear the MAC accumulator
mac_enable  output  1  accumulate the current operand pair
mac_result  input  ACC_WIDTH  MAC accumulator value
res_valid  output  1  result element available
res_ready  input  1  result sink accepts the element
res_addr  output  ADDR_WIDTH  result address (i*N + j)
res_data  output  ACC_WIDTH  result element

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0.
  - All counters and address registers are 0.
  - Reset asserted mid-operation abandons the product. No done pulse. An in-flight res_valid drops immediately.
- States: IDLE, CLEAR, FEED, DRAIN, WRITE, FINISH.
- IDLE:
  - On start=1, latch dim_m/n/k.
  - If any dim is 0, go to FINISH: no reads and no writes; done pulses 2 cycles after start.
  - Otherwise clear i, j, k and go to CLEAR.
  - start while not in IDLE is ignored.
- CLEAR (1 cycle):
  - mac_clear=1.
  - a_addr = i*K and b_addr = j are loaded.
  - Go to FEED.
- FEED (exactly K cycles):
  - rd_en=1 each cycle.
  - a_addr increments by 1 per cycle; b_addr increments by N per cycle.
  - Addresses come from running adders; no multipliers.
  - k counts 0..K-1. Leave for DRAIN when k=K-1.
- mac_enable is rd_en delayed by one register stage, covering the 1-cycle RAM read latency. It is therefore high for exactly K cycles per element.
- DRAIN (exactly 2 cycles):
  - Covers the last RAM read plus the MAC register stage.
  - At the end of DRAIN, capture mac_result into res_data and set res_valid=1.
- WRITE:
  - res_valid, res_data and res_addr are held stable until res_valid&&res_ready.
  - On the handshake, res_valid drops next cycle.
  - Indices advance: j increments; when j wraps (j=N-1 -> 0), i increments. res_addr increments by 1.
  - If the element just written was i=M-1, j=N-1, go to FINISH; otherwise go to CLEAR.
- FINISH (1 cycle):
  - done=1 and busy drops in the same cycle.
  - Return to IDLE.
- busy is 1 in all states other than IDLE and FINISH.
- Cycle budget with res_ready tied high:
  - Per element: K+4 cycles.
  - Total from start to done: M*N*(K+4)+1.
- mac_clear and mac_enable are never high in the same cycle.
- res_data carries no truncation: ACC_WIDTH covers the worst case of (2^DIM_WIDTH-1) * (2^DATA_WIDTH-1)^2.

Test Plan:
- Basic 2x2x2, A=[1,2;3,4], B=[5,6;7,8], res_ready=1 -> writes (addr,data) (0,19),(1,22),(2,43),(3,50) in order; done exactly 25 cycles after start.
- Backpressure: same product, res_ready low for 5 cycles on each element -> res_valid/res_data/res_addr stable while stalled; same four results; done at cycle 45.
- Non-square 1x3x4 (M=1,N=3,K=4), A=[1,1,1,1], B all 2 -> three writes of 8 at addr 0..2; each element shows exactly 4 rd_en cycles and 4 mac_enable cycles; b_addr sequence j, j+3, j+6, j+9.
- Max size 15x15x15 with all operands 255 -> every res_data = 975375; last res_addr = 224; last a_addr and b_addr = 224.
- dim_k=0 with start -> no rd_en and no res_valid; done pulse 2 cycles after start.
- Reset low mid-FEED, and separately mid-WRITE -> all outputs 0 immediately, IDLE, no done. A start after reset release runs the 2x2x2 case correctly. start pulsed while busy is ignored.
